vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator; the next generation of the team's fixed 640x480 VGA controller. Produces hsync/vsync, display-enable, raster coordinates and line/frame strobes for any mode set by parameters, advancing on a pixel clock-enable rather than a dedicated clock. Start and stop requests take effect only on frame boundaries, so displays never see a partial frame. Sits between the pixel-enable divider and the elevator status renderer.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: hsync pulse width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porch/sync widths (lines)
- HSYNC_POL, 0: hsync active level (0 = active-low)
- VSYNC_POL, 0: vsync active level
- CW, 10: coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL), else elaboration error
- FRAME_CW, 8: frame counter width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- pix_en  in  1  pixel tick; raster advances only on cycles where pix_en=1
- enable  in  1  run request (level)
- hsync, vsync  out  1  sync outputs at configured polarity
- de  out  1  display enable (pixel in active area)
- x, y  out  CW  raw horizontal/vertical position, 0..H_TOTAL-1 / 0..V_TOTAL-1
- line_start  out  1  one-clk strobe, output position x=0
- frame_start  out  1  one-clk strobe, output position x=0,y=0
- frame_count  out  FRAME_CW  completed-start counter
- running  out  1  raster active

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch (same vertically).
- Internal h_cnt/v_cnt: on tick while running, h_cnt increments; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps at V_TOTAL-1.
- Decode per position (h,v): de = h<H_ACTIVE && v<V_ACTIVE; hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines, independent of h).
- States: IDLE, RUN, DRAIN.
  - IDLE: counters held 0; outputs idle. On tick with enable=1 -> RUN (running=1 after that edge).
  - RUN: on tick, outputs register decode of current (h_cnt,v_cnt), counters advance. enable=0 -> DRAIN (no visible change).
  - DRAIN: as RUN; enable re-asserted -> back to RUN; on tick where (h_cnt,v_cnt)=(H_TOTAL-1,V_TOTAL-1) outputs that last position, counters wrap to 0, -> IDLE. Next edge after that (tick or not) drives idle values.
- Idle values: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, x=y=0, strobes 0, running=0.
- frame_count increments (mod 2^FRAME_CW) on each edge asserting frame_start.
- Reset: all outputs to idle values, frame_count=0, state IDLE, regardless of mid-frame position; takes priority over pix_en/enable.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Output position lags the counter by one tick: k-th tick after entering RUN drives position k-1 in raster order. enable sampled at tick t -> frame_start on tick t+1.
- hsync, vsync, de, x, y hold between ticks; line_start/frame_start high for exactly one clk (the tick edge), 0 on non-tick cycles.
- pix_en=1 every cycle: line = H_TOTAL clks, frame = H_TOTAL*V_TOTAL clks.
- enable toggled between ticks is ignored unless present on a tick cycle.

## Test plan
- Defaults, pix_en=1, enable=1 from reset release: frame_start every 420000 clks; hsync low 96 clks starting 656 clks after line_start; vsync low 1600 clks starting at line 490; de high 307200 clks/frame.
- Small mode (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1): x sequence 0..7 repeating, hsync high exactly at x=5,6; V_TOTAL=6 lines; frame_count 0->1->2 over two frames.
- pix_en=1 every third cycle: strobes one clk wide; x holds 3 clks per value; line = 2400 clks at defaults.
- Deassert enable mid-frame (y=100): frame finishes through x=799,y=524, then running=0, hsync=vsync=1, no further frame_start; re-assert mid-DRAIN -> frames continue uninterrupted.
- rst asserted at x=300,y=200: next edge all idle values, frame_count=0; restart gives frame_start one tick after enable sampled.
- CW=9 with defaults: elaboration fails.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator on a pixel clock-enable
// Start/stop requests only take effect on frame boundaries; all outputs registered.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int FRAME_CW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_en,
  input  logic                enable,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [CW-1:0]       x,
  output logic [CW-1:0]       y,
  output logic                line_start,
  output logic                frame_start,
  output logic [FRAME_CW-1:0] frame_count,
  output logic                running
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int HS_START  = H_ACTIVE + H_FP;
  localparam int HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START  = V_ACTIVE + V_FP;
  localparam int VS_END    = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if ((64'd1 << CW) < 64'(MAX_TOTAL)) begin : g_cw_check
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                state_q;
  logic [CW-1:0]         h_q, v_q;
  logic [CW-1:0]         h_d, v_d;
  logic                  hsync_q, vsync_q, de_q;
  logic [CW-1:0]         x_q, y_q;
  logic                  line_start_q, frame_start_q, running_q;
  logic [FRAME_CW-1:0]   frame_count_q;

  logic h_last, v_last, de_c, hs_c, vs_c, ls_c, fs_c;

  always_comb begin
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    h_d    = h_last ? '0 : h_q + CW'(1);
    v_d    = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + CW'(1);
    end
    de_c = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    hs_c = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
    // vsync spans whole lines, so it ignores the horizontal position
    vs_c = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
    ls_c = (h_q == '0);
    fs_c = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          h_q       <= '0;
          v_q       <= '0;
          hsync_q   <= ~HSYNC_POL;
          vsync_q   <= ~VSYNC_POL;
          de_q      <= 1'b0;
          x_q       <= '0;
          y_q       <= '0;
          running_q <= 1'b0;
          if (pix_en && enable) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN, S_DRAIN: begin
          if (pix_en) begin
            hsync_q       <= hs_c ? HSYNC_POL : ~HSYNC_POL;
            vsync_q       <= vs_c ? VSYNC_POL : ~VSYNC_POL;
            de_q          <= de_c;
            x_q           <= h_q;
            y_q           <= v_q;
            line_start_q  <= ls_c;
            frame_start_q <= fs_c;
            h_q           <= h_d;
            v_q           <= v_d;
            if (fs_c) begin
              frame_count_q <= frame_count_q + FRAME_CW'(1);
            end
            // a stop request only retires the raster once the last pixel of the frame is out
            if (enable) begin
              state_q <= S_RUN;
            end else if (state_q == S_DRAIN && h_last && v_last) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed table-driven bench for vga_timing_gen
// Small mode (8x6 raster, hsync active-high) checked per cycle; default mode checked on one line.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pix_en, enable;
  logic       hsync, vsync, de, line_start, frame_start, running;
  logic [3:0] x, y;
  logic [1:0] frame_count;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(4), .FRAME_CW(2)
  ) u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .enable(enable),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count), .running(running)
  );

  logic       d_rst, d_en;
  logic       d_hsync, d_vsync, d_de, d_ls, d_fs, d_run;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(d_rst), .pix_en(1'b1), .enable(d_en),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs),
    .frame_count(d_fc), .running(d_run)
  );

  typedef struct {
    logic rst, pe, en;
    logic hs, vs, de;
    int   x, y;
    logic ls, fs, run;
    int   fc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t idle_v(input logic r, pe, en, run, input int fc);
    vec_t v;
    v.rst = r; v.pe = pe; v.en = en;
    v.hs = 1'b0; v.vs = 1'b1; v.de = 1'b0; v.x = 0; v.y = 0;
    v.ls = 1'b0; v.fs = 1'b0; v.run = run; v.fc = fc;
    return v;
  endfunction

  // Expected outputs for the p-th raster position after start (8x6 raster, frame = 48 ticks)
  function automatic vec_t pos_v(input int p, input logic pe, en);
    vec_t v;
    v.rst = 1'b0; v.pe = pe; v.en = en;
    v.x   = p % 8;
    v.y   = (p / 8) % 6;
    v.hs  = (v.x == 5) || (v.x == 6);
    v.vs  = (v.y != 4);
    v.de  = (v.x < 4) && (v.y < 3);
    v.ls  = (v.x == 0);
    v.fs  = (v.x == 0) && (v.y == 0);
    v.run = 1'b1;
    v.fc  = (p / 48 + 1) % 4;
    return v;
  endfunction

  task automatic apply(input vec_t e, input string tag, input int idx);
    rst = e.rst; pix_en = e.pe; enable = e.en;
    @(posedge clk);
    #1;
    n_cmp++;
    if (hsync !== e.hs || vsync !== e.vs || de !== e.de || int'(x) != e.x || int'(y) != e.y ||
        line_start !== e.ls || frame_start !== e.fs || running !== e.run || int'(frame_count) != e.fc) begin
      n_bad++;
      $display("FAIL %s[%0d]: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b fc=%0d, want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b fc=%0d",
               tag, idx, hsync, vsync, de, x, y, line_start, frame_start, running, frame_count,
               e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.run, e.fc);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  initial begin
    vec_t e;
    int   hs_first, hs_len, de_len, waited;
    rst = 1'b1; pix_en = 1'b0; enable = 1'b0;
    d_rst = 1'b1; d_en = 1'b0;

    // Main table: reset, enable on a non-tick (ignored), start, then 200 ticks (frame_count wraps)
    tbl.push_back(idle_v(1'b1, 1'b1, 1'b1, 1'b0, 0));
    tbl.push_back(idle_v(1'b0, 1'b0, 1'b1, 1'b0, 0));
    tbl.push_back(idle_v(1'b0, 1'b1, 1'b1, 1'b1, 0));
    for (int p = 0; p < 200; p++) tbl.push_back(pos_v(p, 1'b1, 1'b1));
    foreach (tbl[i]) apply(tbl[i], "table", i);

    // pix_en every third cycle: values hold, strobes one clk wide
    apply(idle_v(1'b1, 1'b1, 1'b0, 1'b0, 0), "slow_rst", 0);
    for (int c = 0; c < 42; c++) begin
      logic pe;
      pe = (c % 3 == 0);
      if (c < 3) e = idle_v(1'b0, pe, 1'b1, 1'b1, 0);
      else begin
        e = pos_v(c / 3 - 1, pe, 1'b1);
        if (!pe) begin e.ls = 1'b0; e.fs = 1'b0; end
      end
      apply(e, "slow", c);
    end

    // Stop mid-frame: the frame drains to its last position, then idle with no new frame
    apply(idle_v(1'b1, 1'b1, 1'b0, 1'b0, 0), "drain_rst", 0);
    apply(idle_v(1'b0, 1'b1, 1'b1, 1'b1, 0), "drain_go", 0);
    for (int p = 0; p < 48; p++) apply(pos_v(p, 1'b1, p <= 20), "drain", p);
    for (int k = 0; k < 12; k++) apply(idle_v(1'b0, 1'b1, 1'b0, 1'b0, 1), "drain_idle", k);

    // Stop then re-assert within the drain: raster continues without a gap
    apply(idle_v(1'b1, 1'b1, 1'b0, 1'b0, 0), "resume_rst", 0);
    apply(idle_v(1'b0, 1'b1, 1'b1, 1'b1, 0), "resume_go", 0);
    for (int p = 0; p < 100; p++) apply(pos_v(p, 1'b1, !(p >= 10 && p < 15)), "resume", p);

    // Reset mid-frame wins over pix_en/enable, then a clean restart
    apply(idle_v(1'b1, 1'b1, 1'b0, 1'b0, 0), "mrst_rst", 0);
    apply(idle_v(1'b0, 1'b1, 1'b1, 1'b1, 0), "mrst_go", 0);
    for (int p = 0; p < 31; p++) apply(pos_v(p, 1'b1, 1'b1), "mrst_run", p);
    apply(idle_v(1'b1, 1'b1, 1'b1, 1'b0, 0), "mrst_hit", 0);
    apply(idle_v(1'b0, 1'b0, 1'b1, 1'b0, 0), "mrst_gap", 0);
    apply(idle_v(1'b0, 1'b1, 1'b1, 1'b1, 0), "mrst_go2", 0);
    for (int p = 0; p < 3; p++) apply(pos_v(p, 1'b1, 1'b1), "mrst_restart", p);

    // Default 640x480 mode: one full line of horizontal timing
    @(posedge clk); #1;
    check_int("def_idle_hsync", int'(d_hsync), 1);
    d_rst = 1'b0; d_en = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!d_ls && waited < 20);
    check_int("def_first_line_start", int'(d_ls), 1);
    check_int("def_first_frame_start", int'(d_fs), 1);
    hs_first = -1; hs_len = 0; de_len = int'(d_de);
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (n < 800) begin
        if (!d_hsync) begin
          hs_len++;
          if (hs_first < 0) hs_first = n;
        end
        if (d_de) de_len++;
      end
    end
    check_int("def_hsync_start", hs_first, 656);
    check_int("def_hsync_width", hs_len, 96);
    check_int("def_de_per_line", de_len, 640);
    check_int("def_line_period", int'(d_ls), 1);
    check_int("def_next_y", int'(d_y), 1);
    check_int("def_fc", int'(d_fc), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
